// File: rtl/mole_round_ctrl.sv
// Whack-a-mole game sequencer: picks mole holes, times show/gap windows, tracks misses and rounds.
// Optional build macro MOLE_SPEEDUP_EN shortens the show window by one tick per hit.
module mole_round_ctrl #(
  parameter int         TICK_DIV       = 100000,
  parameter int         SHOW_TICKS     = 50,
  parameter int         GAP_TICKS      = 10,
  parameter int         ROUNDS         = 30,
  parameter int         MISS_LIMIT     = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         MIN_SHOW_TICKS = 10
) (
  input  logic       clk,
  input  logic       key_esc_n,
  input  logic       key_space,
  input  logic       cw,
  input  logic       F15,
  input  logic       F5,
  output logic [2:0] mole_pos,
  output logic [2:0] state,
  output logic [7:0] round_cnt,
  output logic [1:0] miss_cnt,
  output logic       game_over,
  output logic       win
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
  if (MISS_LIMIT < 1 || MISS_LIMIT > 3) begin : g_bad_miss
    $error("MISS_LIMIT must fit the 2-bit miss counter");
  end
  if (MIN_SHOW_TICKS < 1 || MIN_SHOW_TICKS > SHOW_TICKS) begin : g_bad_min
    $error("MIN_SHOW_TICKS must be in 1..SHOW_TICKS");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW  = 3'd1,
    GAP   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t        fsm;
  logic [PW-1:0] presc;
  logic [7:0]    timer;
  logic [7:0]    lfsr;
  logic          prev_space;
  logic          saved_gap;
  logic [2:0]    last_idx;
  logic [2:0]    held_pos;
  logic [7:0]    show_lim;

  // Candidate folds 5..7 onto 0..2; a repeat of the previous hole bumps to the next one.
  function automatic logic [2:0] pick_idx(input logic [2:0] rnd, input logic [2:0] prev);
    logic [2:0] c;
    c = (rnd >= 3'd5) ? rnd - 3'd5 : rnd;
    if (c == prev) c = (c == 3'd4) ? 3'd0 : c + 3'd1;
    return c;
  endfunction

  function automatic logic [2:0] idx_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b010;
      3'd1:    code = 3'b001;
      3'd2:    code = 3'b100;
      3'd3:    code = 3'b101;
      3'd4:    code = 3'b011;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  logic       space_edge;
  logic       in_timed;
  logic       tick;
  logic [7:0] timer_inc;
  logic       show_exp;
  logic       gap_exp;
  logic [1:0] miss_next;
  logic       miss_final;
  logic [2:0] next_idx;
  logic       lfsr_fb;

  assign space_edge = key_space & ~prev_space;
  assign in_timed   = (fsm == SHOW) || (fsm == GAP);
  assign tick       = in_timed && (presc == PRESC_MAX);
  assign timer_inc  = timer + 8'd1;
  assign show_exp   = tick && (timer_inc == show_lim);
  assign gap_exp    = tick && (timer_inc == 8'(GAP_TICKS));
  assign miss_next  = miss_cnt + 2'd1;
  assign miss_final = (miss_next == 2'(MISS_LIMIT));
  assign next_idx   = pick_idx(lfsr[2:0], last_idx);
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign state      = fsm;

`ifndef MOLE_SPEEDUP_EN
  assign show_lim = 8'(SHOW_TICKS);
`endif

  always_ff @(posedge clk or negedge key_esc_n) begin
    if (!key_esc_n) begin
      fsm        <= IDLE;
      mole_pos   <= 3'b000;
      round_cnt  <= 8'd0;
      miss_cnt   <= 2'd0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      lfsr       <= LFSR_SEED;
      presc      <= '0;
      timer      <= 8'd0;
      prev_space <= 1'b0;
      saved_gap  <= 1'b0;
      last_idx   <= 3'd7;
      held_pos   <= 3'b000;
`ifdef MOLE_SPEEDUP_EN
      show_lim   <= 8'(SHOW_TICKS);
`endif
    end else begin
      prev_space <= key_space;
      lfsr       <= {lfsr[6:0], lfsr_fb};

      // Free-running tick/timer while a window is open; entries below override with a clear.
      if (in_timed) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) timer <= timer_inc;
      end

      case (fsm)
        IDLE: begin
          mole_pos <= 3'b000;
          if (space_edge) begin
            fsm       <= SHOW;
            last_idx  <= next_idx;
            held_pos  <= idx_code(next_idx);
            mole_pos  <= idx_code(next_idx);
            round_cnt <= 8'd1;
            presc     <= '0;
            timer     <= 8'd0;
          end
        end

        SHOW: begin
          if (F15) begin
            fsm       <= OVER;
            mole_pos  <= 3'b000;
            game_over <= 1'b1;
            win       <= 1'b1;
          end else if (cw) begin
            fsm      <= GAP;
            mole_pos <= 3'b000;
            presc    <= '0;
            timer    <= 8'd0;
`ifdef MOLE_SPEEDUP_EN
            if (show_lim > 8'(MIN_SHOW_TICKS)) show_lim <= show_lim - 8'd1;
`endif
          end else if (show_exp) begin
            miss_cnt <= miss_next;
            mole_pos <= 3'b000;
            if (miss_final) begin
              fsm       <= OVER;
              game_over <= 1'b1;
              win       <= 1'b0;
            end else begin
              fsm   <= GAP;
              presc <= '0;
              timer <= 8'd0;
            end
          end else if (space_edge) begin
            fsm       <= PAUSE;
            saved_gap <= 1'b0;
            mole_pos  <= 3'b000;
          end
        end

        GAP: begin
          mole_pos <= 3'b000;
          if (F15) begin
            fsm       <= OVER;
            game_over <= 1'b1;
            win       <= 1'b1;
          end else if (gap_exp) begin
            if (round_cnt == 8'(ROUNDS)) begin
              fsm       <= OVER;
              game_over <= 1'b1;
              win       <= ~F5;
            end else begin
              fsm       <= SHOW;
              last_idx  <= next_idx;
              held_pos  <= idx_code(next_idx);
              mole_pos  <= idx_code(next_idx);
              round_cnt <= round_cnt + 8'd1;
              presc     <= '0;
              timer     <= 8'd0;
            end
          end else if (space_edge) begin
            fsm       <= PAUSE;
            saved_gap <= 1'b1;
          end
        end

        // Resume keeps prescaler and timer so the remaining window is unchanged.
        PAUSE: begin
          mole_pos <= 3'b000;
          if (space_edge) begin
            fsm      <= saved_gap ? GAP : SHOW;
            mole_pos <= saved_gap ? 3'b000 : held_pos;
          end
        end

        OVER: begin
          mole_pos  <= 3'b000;
          game_over <= 1'b1;
        end

        default: begin
          fsm      <= IDLE;
          mole_pos <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed self-checking bench for mole_round_ctrl with small timing parameters (4 clk/tick).
module tb_mole_round_ctrl;

  logic       clk = 1'b0;
  logic       key_esc_n;
  logic       key_space;
  logic       cw;
  logic       F15;
  logic       F5;
  logic [2:0] mole_pos;
  logic [2:0] state;
  logic [7:0] round_cnt;
  logic [1:0] miss_cnt;
  logic       game_over;
  logic       win;

  int total = 0;
  int bad   = 0;

  mole_round_ctrl #(
    .TICK_DIV(4), .SHOW_TICKS(3), .GAP_TICKS(2), .ROUNDS(4), .MISS_LIMIT(2),
    .LFSR_SEED(8'hA5), .MIN_SHOW_TICKS(1)
  ) dut (
    .clk(clk), .key_esc_n(key_esc_n), .key_space(key_space), .cw(cw), .F15(F15), .F5(F5),
    .mole_pos(mole_pos), .state(state), .round_cnt(round_cnt), .miss_cnt(miss_cnt),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic press_space();
    key_space = 1'b1;
    step();
    key_space = 1'b0;
  endtask

  task automatic do_reset();
    key_esc_n = 1'b0; key_space = 1'b0; cw = 1'b0; F15 = 1'b0; F5 = 1'b0;
    steps(2);
    key_esc_n = 1'b1;
    step();
  endtask

  function automatic bit pos_ok(input logic [2:0] p);
    return p inside {3'b010, 3'b001, 3'b100, 3'b101, 3'b011};
  endfunction

  task automatic test_reset();
    do_reset();
    press_space();
    steps(3);
    key_esc_n = 1'b0;
    #2;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if (mole_pos !== 3'b000) begin bad++; $display("FAIL rst_pos got=%b want=000", mole_pos); end
    total++; if (round_cnt !== 8'd0) begin bad++; $display("FAIL rst_round got=%0d want=0", round_cnt); end
    total++; if (miss_cnt !== 2'd0) begin bad++; $display("FAIL rst_miss got=%0d want=0", miss_cnt); end
    total++; if (game_over !== 1'b0 || win !== 1'b0) begin bad++; $display("FAIL rst_over got=%b%b want=00", game_over, win); end
    step();
    key_esc_n = 1'b1;
    steps(2);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_idle_hold got=%0d want=0", state); end
  endtask

  task automatic test_show_gap_timing();
    logic [2:0] first;
    int hold, gap;
    do_reset();
    press_space();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL t1_state got=%0d want=1", state); end
    total++; if (!pos_ok(mole_pos)) begin bad++; $display("FAIL t1_pos got=%b want=valid code", mole_pos); end
    total++; if (round_cnt !== 8'd1) begin bad++; $display("FAIL t1_round got=%0d want=1", round_cnt); end
    first = mole_pos;
    hold = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (mole_pos !== first || state !== 3'd1) break;
      hold++;
    end
    total++; if (hold !== 12) begin bad++; $display("FAIL t1_show_len got=%0d want=12", hold); end
    total++; if (state !== 3'd2 || mole_pos !== 3'b000) begin bad++; $display("FAIL t1_gap_entry got=%0d/%b want=2/000", state, mole_pos); end
    total++; if (miss_cnt !== 2'd1) begin bad++; $display("FAIL t1_miss got=%0d want=1", miss_cnt); end
    gap = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (state !== 3'd2 || mole_pos !== 3'b000) break;
      gap++;
    end
    total++; if (gap !== 8) begin bad++; $display("FAIL t1_gap_len got=%0d want=8", gap); end
    total++; if (state !== 3'd1 || round_cnt !== 8'd2) begin bad++; $display("FAIL t1_next got=%0d/%0d want=1/2", state, round_cnt); end
    total++; if (!pos_ok(mole_pos) || mole_pos === first) begin bad++; $display("FAIL t1_next_pos got=%b want=valid and not %b", mole_pos, first); end
  endtask

  task automatic test_hit();
    int hits;
    do_reset();
    press_space();
    steps(2);
    cw = 1'b1;
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      if (mole_pos !== 3'b000) hits++;
      step();
      if (k == 0) begin
        total++; if (state !== 3'd2) begin bad++; $display("FAIL t2_state got=%0d want=2", state); end
        total++; if (mole_pos !== 3'b000) begin bad++; $display("FAIL t2_clear got=%b want=000", mole_pos); end
      end
    end
    cw = 1'b0;
    total++; if (hits !== 1) begin bad++; $display("FAIL t2_score got=%0d want=1", hits); end
    total++; if (miss_cnt !== 2'd0) begin bad++; $display("FAIL t2_miss got=%0d want=0", miss_cnt); end
    steps(4);
    total++; if (state !== 3'd1 || round_cnt !== 8'd2) begin bad++; $display("FAIL t2_next got=%0d/%0d want=1/2", state, round_cnt); end
  endtask

  task automatic test_hit_at_expiry();
    do_reset();
    press_space();
    steps(11);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL exp_last_cycle got=%0d want=1", state); end
    cw = 1'b1;
    step();
    cw = 1'b0;
    total++; if (state !== 3'd2 || miss_cnt !== 2'd0) begin bad++; $display("FAIL exp_hit got=%0d/%0d want=2/0", state, miss_cnt); end
  endtask

  task automatic test_miss_over();
    do_reset();
    press_space();
    steps(12);
    total++; if (state !== 3'd2 || miss_cnt !== 2'd1) begin bad++; $display("FAIL t3_miss1 got=%0d/%0d want=2/1", state, miss_cnt); end
    steps(8);
    total++; if (state !== 3'd1 || round_cnt !== 8'd2) begin bad++; $display("FAIL t3_show2 got=%0d/%0d want=1/2", state, round_cnt); end
    steps(12);
    total++; if (state !== 3'd4 || game_over !== 1'b1) begin bad++; $display("FAIL t3_over got=%0d/%b want=4/1", state, game_over); end
    total++; if (win !== 1'b0 || miss_cnt !== 2'd2) begin bad++; $display("FAIL t3_lose got=%b/%0d want=0/2", win, miss_cnt); end
    steps(3);
    press_space();
    steps(2);
    total++; if (state !== 3'd4 || mole_pos !== 3'b000) begin bad++; $display("FAIL t3_sticky got=%0d/%b want=4/000", state, mole_pos); end
  endtask

  task automatic test_pause();
    logic [2:0] first;
    int rem;
    do_reset();
    press_space();
    first = mole_pos;
    steps(4);
    press_space();
    total++; if (state !== 3'd3 || mole_pos !== 3'b000) begin bad++; $display("FAIL t4_pause got=%0d/%b want=3/000", state, mole_pos); end
    steps(40);
    total++; if (state !== 3'd3 || round_cnt !== 8'd1) begin bad++; $display("FAIL t4_hold got=%0d/%0d want=3/1", state, round_cnt); end
    press_space();
    total++; if (state !== 3'd1 || mole_pos !== first) begin bad++; $display("FAIL t4_resume got=%0d/%b want=1/%b", state, mole_pos, first); end
    rem = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (state !== 3'd1) break;
      rem++;
    end
    total++; if (rem !== 7) begin bad++; $display("FAIL t4_remaining got=%0d want=7", rem); end
    total++; if (state !== 3'd2 || round_cnt !== 8'd1) begin bad++; $display("FAIL t4_after got=%0d/%0d want=2/1", state, round_cnt); end
    press_space();
    steps(10);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL t4_gap_pause got=%0d want=3", state); end
    press_space();
    rem = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (state !== 3'd2) break;
      rem++;
    end
    total++; if (rem !== 7) begin bad++; $display("FAIL t4_gap_remaining got=%0d want=7", rem); end
    total++; if (state !== 3'd1 || round_cnt !== 8'd2) begin bad++; $display("FAIL t4_gap_next got=%0d/%0d want=1/2", state, round_cnt); end
  endtask

  task automatic test_full_game(input logic f5, input logic exp_win);
    do_reset();
    F5 = f5;
    press_space();
    for (int r = 1; r <= 4; r++) begin
      total++; if (state !== 3'd1 || round_cnt !== 8'(r)) begin bad++; $display("FAIL t5_round%0d got=%0d/%0d want=1/%0d", r, state, round_cnt, r); end
      cw = 1'b1;
      step();
      cw = 1'b0;
      steps(8);
    end
    total++; if (state !== 3'd4 || game_over !== 1'b1) begin bad++; $display("FAIL t5_over_f5_%b got=%0d/%b want=4/1", f5, state, game_over); end
    total++; if (win !== exp_win || round_cnt !== 8'd4) begin bad++; $display("FAIL t5_win_f5_%b got=%b/%0d want=%b/4", f5, win, round_cnt, exp_win); end
    F5 = 1'b0;
  endtask

  task automatic test_f15();
    do_reset();
    press_space();
    steps(2);
    F15 = 1'b1;
    cw = 1'b1;
    step();
    F15 = 1'b0;
    cw = 1'b0;
    total++; if (state !== 3'd4 || win !== 1'b1) begin bad++; $display("FAIL t5_f15 got=%0d/%b want=4/1", state, win); end
    total++; if (game_over !== 1'b1 || mole_pos !== 3'b000) begin bad++; $display("FAIL t5_f15_out got=%b/%b want=1/000", game_over, mole_pos); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev;
    for (int g = 0; g < 50; g++) begin
      do_reset();
      steps($urandom_range(0, 40));
      press_space();
      prev = 3'b000;
      for (int r = 0; r < 4; r++) begin
        total++;
        if (!pos_ok(mole_pos) || mole_pos === prev) begin
          bad++; $display("FAIL repeat g%0d r%0d got=%b want=valid and not %b", g, r, mole_pos, prev);
        end
        prev = mole_pos;
        steps($urandom_range(0, 8));
        cw = 1'b1;
        step();
        cw = 1'b0;
        steps(8);
      end
    end
  endtask

`ifdef MOLE_SPEEDUP_EN
  task automatic test_speedup();
    int exp_len [3] = '{12, 8, 4};
    int len;
    do_reset();
    press_space();
    for (int i = 0; i < 3; i++) begin
      len = 1;
      for (int k = 0; k < 30; k++) begin
        if (len == exp_len[i]) cw = 1'b1;
        step();
        cw = 1'b0;
        if (state !== 3'd1) break;
        len++;
      end
      total++; if (len !== exp_len[i] || miss_cnt !== 2'd0) begin bad++; $display("FAIL t6_len%0d got=%0d/%0d want=%0d/0", i, len, miss_cnt, exp_len[i]); end
      steps(8);
    end
    len = 1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (state !== 3'd1) break;
      len++;
    end
    total++; if (len !== 4 || miss_cnt !== 2'd1) begin bad++; $display("FAIL t6_len3 got=%0d/%0d want=4/1", len, miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_show_gap_timing();
    test_hit();
    test_hit_at_expiry();
    test_miss_over();
    test_pause();
    test_full_game(1'b0, 1'b1);
    test_full_game(1'b1, 1'b0);
    test_f15();
    test_back_to_back();
`ifdef MOLE_SPEEDUP_EN
    test_speedup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
